// File: rtl/t03_clock_divider_multi.sv
// Multi-channel programmable tick/clock divider on hwclk.
// Each channel divides by div_act+1 and double-buffers divisor writes until a period boundary.
module t03_clock_divider_multi #(
    parameter int NUM_CH      = 4,
    parameter int CTR_W       = 23,
    parameter int DEFAULT_DIV = 5000000,
    parameter int SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              hwclk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic [NUM_CH-1:0] mode,
    input  logic              sync_clr,
    input  logic              div_wr,
    input  logic [SEL_W-1:0]  div_sel,
    input  logic [CTR_W-1:0]  div_data,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clkout,
    output logic [NUM_CH-1:0] pend
);

    localparam logic [CTR_W-1:0] DEF_DIV = DEFAULT_DIV[CTR_W-1:0];
    localparam logic [CTR_W-1:0] ONE     = {{(CTR_W-1){1'b0}}, 1'b1};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CTR_W-1:0] ctr;
        logic [CTR_W-1:0] div_act;
        logic [CTR_W-1:0] div_shd;
        logic             pend_r;
        logic             tick_r;
        logic             clk_r;
        logic             tc;
        logic             wr_hit;
        logic             apply;

        assign tc     = en[i] && (ctr == div_act);
        // Out-of-range div_sel never matches any channel index.
        assign wr_hit = div_wr && (32'(div_sel) == i);
        // Any point where no period is in progress may take the shadow divisor.
        assign apply  = sync_clr || !en[i] || tc;

        always_ff @(posedge hwclk or posedge rst) begin
            if (rst) begin
                ctr     <= '0;
                div_act <= DEF_DIV;
                div_shd <= DEF_DIV;
                pend_r  <= 1'b0;
                tick_r  <= 1'b0;
                clk_r   <= 1'b0;
            end else begin
                if (pend_r && apply) begin
                    div_act <= div_shd;
                end

                // A write in an apply cycle re-arms pend for the following boundary.
                if (wr_hit) begin
                    div_shd <= div_data;
                    pend_r  <= 1'b1;
                end else if (apply) begin
                    pend_r  <= 1'b0;
                end

                if (sync_clr || !en[i]) begin
                    ctr    <= '0;
                    tick_r <= 1'b0;
                    clk_r  <= 1'b0;
                end else if (tc) begin
                    ctr    <= '0;
                    tick_r <= 1'b1;
                    clk_r  <= mode[i] ? ~clk_r : 1'b1;
                end else begin
                    ctr    <= ctr + ONE;
                    tick_r <= 1'b0;
                    clk_r  <= mode[i] ? clk_r : 1'b0;
                end
            end
        end

        assign tick[i]   = tick_r;
        assign clkout[i] = clk_r;
        assign pend[i]   = pend_r;
    end

endmodule

// File: doc/t03_clock_divider_multi.md
Name: t03_clock_divider_multi

Overview:
Multi-channel programmable clock/tick generator running on hwclk. Each channel divides hwclk by a runtime-programmable divisor and produces a one-cycle tick strobe plus a clock-like output, either pulse or 50% square. Divisor updates are double-buffered and take effect only at a period boundary, so periods are never truncated. The block feeds slow-timebase consumers such as display refresh, debounce and game-tick logic from a single instance.

Parameters:
- NUM_CH, 4, number of independent divider channels (1..8).
- CTR_W, 23, width of the per-channel counter and divisor.
- DEFAULT_DIV, 5000000, divisor loaded into every channel at reset. Must fit in CTR_W bits.
- SEL_W, $clog2(NUM_CH) (min 1), width of div_sel.

Ports:
- hwclk  input  1  system clock; all state is updated on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- en  input  NUM_CH  per-channel run enable.
- mode  input  NUM_CH  per-channel output mode: 0 = pulse, 1 = square.
- sync_clr  input  1  synchronous restart of all channels.
- div_wr  input  1  divisor write strobe.
- div_sel  input  SEL_W  channel index for the write.
- div_data  input  CTR_W  new divisor value.
- tick  output  NUM_CH  one-cycle strobe at each period end.
- clkout  output  NUM_CH  divided clock output.
- pend  output  NUM_CH  high while a written divisor waits to be applied.

Behaviour:
- Per-channel state: ctr[CTR_W], div_act[CTR_W], div_shd[CTR_W], pend, tick, clkout. All outputs are registered.
- Reset, applied asynchronously on rst:
  - ctr = 0, div_act = div_shd = DEFAULT_DIV.
  - pend = 0, tick = 0, clkout = 0.
- Period: period = div_act + 1 hwclk cycles. A channel reaches terminal count (tc) when en = 1 and ctr == div_act.
- Running channel (en = 1, sync_clr = 0):
  - On tc: ctr <= 0 and tick <= 1.
  - Otherwise: ctr <= ctr + 1 and tick <= 0.
  - Because tick is registered, it is high during the cycle after ctr == div_act.
- Latency: en rises with ctr = 0 at edge 0. The first tick is high in the cycle following edge div_act + 1. Later ticks repeat every div_act + 1 cycles.
- clkout:
  - Square mode: toggles on every tc edge, giving period 2*(div_act + 1) and 50% duty.
  - Pulse mode: clkout <= tc, so it equals tick.
  - mode is sampled every cycle. Switching to square continues toggling from the current clkout value.
- Disabled channel (en = 0): ctr <= 0, tick <= 0, clkout <= 0. If pend = 1, then div_act <= div_shd and pend <= 0 immediately.
- Divisor write: when div_wr = 1 and div_sel < NUM_CH, the selected channel loads div_shd <= div_data and sets pend <= 1. Writes with div_sel >= NUM_CH are ignored.
- Applying a pending divisor: on a tc edge with pend = 1, div_act <= div_shd and pend <= 0. The period that starts at that edge uses the new value.
- Write in the same cycle as tc on the same channel:
  - div_shd takes the new data and pend stays 1.
  - div_act at that tc takes the old div_shd if pend was already set; otherwise div_act is unchanged.
  - The new value applies at the following tc.
- Repeated writes before tc: the last write wins.
- sync_clr = 1: on all channels, ctr <= 0, tick <= 0, clkout <= 0, and any pending divisor is applied. sync_clr has priority over tc and en. A div_wr in the same cycle still updates div_shd and sets pend.
- div_act = 0: tc occurs every cycle. tick is held high continuously. Square clkout = hwclk/2.
- Counter width: ctr never exceeds div_act. No wrap past 2^CTR_W - 1 is possible.
- rst asserted mid-operation: all state returns to reset values immediately. Pending writes are discarded.
- Channels are fully independent. Simultaneous tc on several channels is allowed.

Test Plan:
- Reset and default period: NUM_CH=2, CTR_W=8, DEFAULT_DIV=4, en=2'b01, mode=0 → tick[0] pulses every 5 cycles, first high in the cycle after edge 5. tick[1] and clkout[1] stay 0.
- Square mode: DEFAULT_DIV=2, mode[0]=1 → clkout[0] is 3 cycles high, 3 cycles low. Toggle edges coincide with tick[0] rising.
- Double-buffered reload: running with div=4, write div_data=1 mid-period → pend[0]=1 until the next tc. That period remains 5 cycles, then periods are 2 cycles and pend clears.
- Write on tc: write div_data=7 exactly on a tc cycle with no prior pend → the next period is still the old value. div_act=7 takes effect at the following tc.
- Disabled load and sync_clr: en[0]=0, write 3 → div_act=3 next cycle, pend=0. Then run, assert sync_clr mid-period → ctr, tick and clkout are 0 next cycle, and the period restarts with a full 4 cycles.
- Edge cases:
  - div=0 → tick is constantly 1 and square clkout toggles every cycle.
  - div_sel=3 with NUM_CH=2 → no state change.
  - rst pulse mid-period → all outputs are 0 asynchronously, div_act returns to DEFAULT_DIV and pend clears.
